// File: rtl/ndn_pkg.sv
// Shared widths, direction encoding and arbiter state type for the NDN
// forwarding-plane blocks.
package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fib_req_slot.sv
// One-entry pending slot: captures a held request, pulses ack the next cycle,
// and re-arms only after the requester has dropped req for at least one cycle.
module fib_req_slot
  import ndn_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [LEN_W-1:0]    len,
  input  logic                clear,
  output logic                ack,
  output logic                full,
  output logic [PREFIX_W-1:0] slot_prefix,
  output logic [LEN_W-1:0]    slot_len
);

  logic armed;
  logic capture;

  assign capture = req && !full && !ack && armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack         <= 1'b0;
      full        <= 1'b0;
      armed       <= 1'b1;
      slot_prefix <= '0;
      slot_len    <= '0;
    end else begin
      ack <= capture;
      if (capture) begin
        full        <= 1'b1;
        slot_prefix <= prefix;
        slot_len    <= len;
      end else if (clear) begin
        full <= 1'b0;
      end
      // A requester still holding req after its ack must not be taken twice.
      if (!req) begin
        armed <= 1'b1;
      end else if (capture) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fib_request_arbiter.sv
// Arbitrates PIT outgoing and SPI incoming lookups onto one FIB port with
// round-robin on contention, a wait timeout and a one-cycle response pulse.
module fib_request_arbiter
  import ndn_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
  parameter logic       FIRST_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                out_req,
  input  logic [PREFIX_W-1:0] out_prefix,
  input  logic [LEN_W-1:0]    out_len,
  output logic                out_ack,
  input  logic                in_req,
  input  logic [PREFIX_W-1:0] in_prefix,
  input  logic [LEN_W-1:0]    in_len,
  output logic                in_ack,
  output logic                fib_valid,
  output logic [PREFIX_W-1:0] fib_prefix,
  output logic [LEN_W-1:0]    fib_len,
  output logic                fib_dir,
  input  logic                fib_ready,
  input  logic                fib_done,
  input  logic                fib_hit,
  input  logic                fib_rejected,
  output logic                resp_valid,
  output logic                resp_dir,
  output logic                resp_hit,
  output logic                resp_rejected,
  output logic                resp_timeout,
  output state_t              dbg_state
);

  // FIB handshake: fib_valid and its payload are driven from registers only and
  // stay constant until the edge where fib_valid && fib_ready; that edge is the
  // transfer. fib_done is a one-cycle completion pulse honoured only in WAIT.

  state_t              state, state_n;
  logic                out_full, in_full;
  logic [PREFIX_W-1:0] out_slot_prefix, in_slot_prefix;
  logic [LEN_W-1:0]    out_slot_len, in_slot_len;
  logic                clr_out, clr_in;

  logic                g_dir, last_grant;
  logic [PREFIX_W-1:0] g_prefix;
  logic [LEN_W-1:0]    g_len;
  logic [7:0]          timer;
  logic                r_hit, r_rej, r_to;

  logic                contested, pick_dir, load_grant, set_resp, clr_timer;
  logic                hit_n, rej_n, to_n;
  logic [PREFIX_W-1:0] pick_prefix;
  logic [LEN_W-1:0]    pick_len;

  fib_req_slot u_out_slot (
    .clk         (clk),
    .rst         (rst),
    .req         (out_req),
    .prefix      (out_prefix),
    .len         (out_len),
    .clear       (clr_out),
    .ack         (out_ack),
    .full        (out_full),
    .slot_prefix (out_slot_prefix),
    .slot_len    (out_slot_len)
  );

  fib_req_slot u_in_slot (
    .clk         (clk),
    .rst         (rst),
    .req         (in_req),
    .prefix      (in_prefix),
    .len         (in_len),
    .clear       (clr_in),
    .ack         (in_ack),
    .full        (in_full),
    .slot_prefix (in_slot_prefix),
    .slot_len    (in_slot_len)
  );

  assign contested   = out_full && in_full;
  assign pick_dir    = contested ? ~last_grant : (in_full ? DIR_IN : DIR_OUT);
  assign pick_prefix = (pick_dir == DIR_IN) ? in_slot_prefix : out_slot_prefix;
  assign pick_len    = (pick_dir == DIR_IN) ? in_slot_len : out_slot_len;

  always_comb begin
    state_n    = state;
    load_grant = 1'b0;
    set_resp   = 1'b0;
    clr_timer  = 1'b0;
    clr_out    = 1'b0;
    clr_in     = 1'b0;
    hit_n      = 1'b0;
    rej_n      = 1'b0;
    to_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (out_full || in_full) begin
          load_grant = 1'b1;
          if (pick_len == '0) begin
            // Zero-length prefix is rejected locally without a FIB lookup.
            state_n  = ST_RESP;
            set_resp = 1'b1;
            rej_n    = 1'b1;
            clr_out  = (pick_dir == DIR_OUT);
            clr_in   = (pick_dir == DIR_IN);
          end else begin
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (fib_ready) begin
          state_n   = ST_WAIT;
          clr_timer = 1'b1;
          clr_out   = (g_dir == DIR_OUT);
          clr_in    = (g_dir == DIR_IN);
        end
      end
      ST_WAIT: begin
        if (fib_done) begin
          state_n  = ST_RESP;
          set_resp = 1'b1;
          hit_n    = fib_hit;
          rej_n    = fib_rejected;
        end else if (timer == TIMEOUT_CYCLES - 8'd1) begin
          state_n  = ST_RESP;
          set_resp = 1'b1;
          to_n     = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      g_dir      <= DIR_OUT;
      g_prefix   <= '0;
      g_len      <= '0;
      last_grant <= ~FIRST_PRIORITY;
      timer      <= 8'd0;
      r_hit      <= 1'b0;
      r_rej      <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      state <= state_n;
      if (load_grant) begin
        g_dir    <= pick_dir;
        g_prefix <= pick_prefix;
        g_len    <= pick_len;
        // Round-robin pointer only moves when both directions competed.
        if (contested) last_grant <= pick_dir;
      end
      if (clr_timer) begin
        timer <= 8'd0;
      end else if (state == ST_WAIT && !fib_done && timer != 8'hFF) begin
        timer <= timer + 8'd1;
      end
      if (set_resp) begin
        r_hit <= hit_n;
        r_rej <= rej_n;
        r_to  <= to_n;
      end
    end
  end

  assign fib_valid     = (state == ST_ISSUE);
  assign fib_prefix    = g_prefix;
  assign fib_len       = g_len;
  assign fib_dir       = g_dir;
  assign resp_valid    = (state == ST_RESP);
  assign resp_dir      = g_dir;
  assign resp_hit      = r_hit;
  assign resp_rejected = r_rej;
  assign resp_timeout  = r_to;
  assign dbg_state     = state;

endmodule

// File: tb/tb_fib_request_arbiter.sv
// Directed bench for fib_request_arbiter; responses are scored against an
// expected queue of {dir, hit, rejected, timeout}.
module tb_fib_request_arbiter;
  import ndn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_req, in_req;
  logic [63:0] out_prefix, in_prefix;
  logic [5:0]  out_len, in_len;
  logic        out_ack, in_ack;
  logic        fib_valid, fib_dir, fib_ready, fib_done, fib_hit, fib_rejected;
  logic [63:0] fib_prefix;
  logic [5:0]  fib_len;
  logic        resp_valid, resp_dir, resp_hit, resp_rejected, resp_timeout;
  state_t      dbg_state;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  fib_request_arbiter #(.TIMEOUT_CYCLES(8'd4), .FIRST_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .out_req(out_req), .out_prefix(out_prefix), .out_len(out_len), .out_ack(out_ack),
    .in_req(in_req), .in_prefix(in_prefix), .in_len(in_len), .in_ack(in_ack),
    .fib_valid(fib_valid), .fib_prefix(fib_prefix), .fib_len(fib_len), .fib_dir(fib_dir),
    .fib_ready(fib_ready), .fib_done(fib_done), .fib_hit(fib_hit), .fib_rejected(fib_rejected),
    .resp_valid(resp_valid), .resp_dir(resp_dir), .resp_hit(resp_hit),
    .resp_rejected(resp_rejected), .resp_timeout(resp_timeout), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic dir, input logic [63:0] p, input logic [5:0] l);
    if (dir == DIR_IN) begin
      in_req = 1'b1; in_prefix = p; in_len = l;
    end else begin
      out_req = 1'b1; out_prefix = p; out_len = l;
    end
    tick();
    check(dir ? "in_ack_pulse" : "out_ack_pulse", 64'(dir ? in_ack : out_ack), 64'd1);
    if (dir == DIR_IN) in_req = 1'b0;
    else out_req = 1'b0;
  endtask

  task automatic wait_fib();
    int n = 0;
    while (!fib_valid && n < 50) begin
      tick();
      n++;
    end
    check("fib_valid_seen", 64'(fib_valid), 64'd1);
  endtask

  task automatic serve(input logic dir, input logic [63:0] p, input logic [5:0] l,
                       input int delay, input logic hit, input logic rej);
    wait_fib();
    check("fib_dir", 64'(fib_dir), 64'(dir));
    check("fib_prefix", fib_prefix, p);
    check("fib_len", 64'(fib_len), 64'(l));
    repeat (delay) tick();
    fib_done = 1'b1; fib_hit = hit; fib_rejected = rej;
    tick();
    fib_done = 1'b0; fib_hit = 1'b0; fib_rejected = 1'b0;
    check("resp_after_done", 64'(resp_valid), 64'd1);
    tick();
  endtask

  // Transfer at cycle c, WAIT counts 0..3 over c+1..c+4, response at c+5.
  task automatic timeout_case(input logic done_last);
    exp_q.push_back(done_last ? 4'b1100 : 4'b1001);
    send(DIR_IN, 64'hDEAD_BEEF_0000_0001, 6'd20);
    wait_fib();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("timeout_no_early_resp", 64'(resp_valid), 64'd0);
      if (k == 4 && done_last) begin
        fib_done = 1'b1; fib_hit = 1'b1;
      end
    end
    tick();
    fib_done = 1'b0; fib_hit = 1'b0;
    check("timeout_resp_cycle", 64'(resp_valid), 64'd1);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("resp_fields", 64'({resp_dir, resp_hit, resp_rejected, resp_timeout}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b0;
    out_req = 1'b0; out_prefix = '0; out_len = '0;
    in_req = 1'b0; in_prefix = '0; in_len = '0;
    fib_ready = 1'b1; fib_done = 1'b0; fib_hit = 1'b0; fib_rejected = 1'b0;
    repeat (3) tick();
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_fib_valid", 64'(fib_valid), 64'd0);
    check("rst_fib_prefix", fib_prefix, 64'd0);
    check("rst_acks", 64'({out_ack, in_ack}), 64'd0);
    check("rst_resp", 64'({resp_valid, resp_dir, resp_hit, resp_rejected, resp_timeout}), 64'd0);
    rst = 1'b1;
    tick();

    // Basic outgoing hit; requester keeps req high well past its ack.
    exp_q.push_back(4'b0100);
    out_req = 1'b1; out_prefix = 64'h0000FFFF0000FFFF; out_len = 6'd10;
    tick();
    check("basic_ack_t1", 64'(out_ack), 64'd1);
    check("basic_no_valid_t1", 64'(fib_valid), 64'd0);
    tick();
    check("basic_valid_t2", 64'(fib_valid), 64'd1);
    check("basic_prefix", fib_prefix, 64'h0000FFFF0000FFFF);
    check("basic_len_dir", 64'({fib_len, fib_dir}), 64'({6'd10, 1'b0}));
    check("basic_ack_once", 64'(out_ack), 64'd0);
    tick();
    check("basic_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    tick();
    tick();
    fib_done = 1'b1; fib_hit = 1'b1;
    tick();
    fib_done = 1'b0; fib_hit = 1'b0;
    check("basic_resp", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("held_req_not_recaptured", 64'({out_ack, fib_valid, resp_valid}), 64'd0);
    end
    out_req = 1'b0;
    tick();

    // Contention: outgoing first after reset, then incoming first.
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1100);
    out_req = 1'b1; out_prefix = 64'h1111_2222_3333_4444; out_len = 6'd8;
    in_req = 1'b1; in_prefix = 64'h5555_6666_7777_8888; in_len = 6'd12;
    tick();
    check("rr1_both_ack", 64'({out_ack, in_ack}), 64'b11);
    out_req = 1'b0; in_req = 1'b0;
    serve(DIR_OUT, 64'h1111_2222_3333_4444, 6'd8, 2, 1'b1, 1'b0);
    serve(DIR_IN, 64'h5555_6666_7777_8888, 6'd12, 1, 1'b1, 1'b0);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0000);
    out_req = 1'b1; out_prefix = 64'h0A0A_0A0A_0A0A_0A0A; out_len = 6'd33;
    in_req = 1'b1; in_prefix = 64'h0B0B_0B0B_0B0B_0B0B; in_len = 6'd63;
    tick();
    check("rr2_both_ack", 64'({out_ack, in_ack}), 64'b11);
    out_req = 1'b0; in_req = 1'b0;
    serve(DIR_IN, 64'h0B0B_0B0B_0B0B_0B0B, 6'd63, 3, 1'b0, 1'b0);
    serve(DIR_OUT, 64'h0A0A_0A0A_0A0A_0A0A, 6'd33, 2, 1'b0, 1'b0);

    // Incoming, FIB rejects.
    begin
      logic [63:0] p;
      p = {$urandom, $urandom};
      exp_q.push_back(4'b1010);
      send(DIR_IN, p, 6'd10);
      serve(DIR_IN, p, 6'd10, $urandom_range(1, 3), 1'b0, 1'b1);
    end

    timeout_case(1'b0);
    timeout_case(1'b1);

    // Zero-length prefix bypasses the FIB.
    exp_q.push_back(4'b0010);
    out_req = 1'b1; out_prefix = 64'h1234; out_len = 6'd0;
    tick();
    check("len0_ack", 64'(out_ack), 64'd1);
    check("len0_no_valid_t1", 64'(fib_valid), 64'd0);
    out_req = 1'b0;
    tick();
    check("len0_resp_t2", 64'({resp_valid, fib_valid}), 64'b10);
    tick();

    // Reset asserted during WAIT discards the transaction.
    send(DIR_OUT, 64'hCAFE_F00D_CAFE_F00D, 6'd5);
    wait_fib();
    tick();
    tick();
    check("pre_reset_wait", 64'(dbg_state), 64'(ST_WAIT));
    #2 rst = 1'b0;
    #1;
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("midrst_fib", 64'({fib_valid, fib_dir, fib_len}), 64'd0);
    check("midrst_prefix", fib_prefix, 64'd0);
    check("midrst_resp", 64'({resp_valid, resp_hit, resp_rejected, resp_timeout}), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    fib_done = 1'b1; fib_hit = 1'b1;
    tick();
    fib_done = 1'b0; fib_hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("post_reset_quiet", 64'({fib_valid, resp_valid}), 64'd0);
      tick();
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_request_arbiter.md
FIB_REQUEST_ARBITER -- requirements
Module: fib_request_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd255; max FIB cycles in WAIT before forced timeout response.
REQ-002 Parameter FIRST_PRIORITY, default 1'b0; direction granted first after reset (0 = outgoing, 1 = incoming).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 out_req  input  1  PIT outgoing interest request, held until out_ack.
REQ-006 out_prefix / out_len  input  64 / 6  outgoing prefix and length, stable while out_req high.
REQ-007 out_ack  output  1  one-cycle pulse: outgoing request captured.
REQ-008 in_req  input  1  SPI incoming data request, held until in_ack.
REQ-009 in_prefix / in_len  input  64 / 6  incoming prefix and length, stable while in_req high.
REQ-010 in_ack  output  1  one-cycle pulse: incoming request captured.
REQ-011 fib_valid  output  1  lookup request to FIB.
REQ-012 fib_prefix / fib_len / fib_dir  output  64 / 6 / 1  granted request; dir 0 = outgoing, 1 = incoming.
REQ-013 fib_ready  input  1  FIB accepts request when fib_valid && fib_ready.
REQ-014 fib_done / fib_hit / fib_rejected  input  1 / 1 / 1  FIB completion pulse and qualifiers.
REQ-015 resp_valid  output  1  one-cycle response pulse.
REQ-016 resp_dir / resp_hit / resp_rejected / resp_timeout  output  1 each  response qualifiers, valid with resp_valid.

Function
REQ-017 Each direction SHALL own a one-entry pending slot; on a clock edge with req=1 and slot empty, slot captures prefix/len and ack pulses the following cycle.
REQ-018 req while slot full or ack pending SHALL be ignored; a requester holding req after ack SHALL NOT be captured twice (capture requires req low for >=1 cycle after ack).
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if one slot pending -> grant it; both pending -> grant opposite of last_grant (round-robin); last_grant resets to !FIRST_PRIORITY; none -> stay.
REQ-021 Granted slot with len = 0 SHALL skip FIB: go to RESP with resp_rejected=1, hit=0, timeout=0; slot cleared.
REQ-022 ISSUE: fib_valid=1 with granted prefix/len/dir held constant until fib_valid && fib_ready; on that edge slot clears, timer clears, -> WAIT.
REQ-023 WAIT: fib_done=1 -> latch fib_hit, fib_rejected -> RESP; else timer increments (8-bit, saturating); timer = TIMEOUT_CYCLES-1 without done -> RESP with resp_timeout=1, hit=0, rejected=0.
REQ-024 fib_done and timeout in same cycle: done wins, timeout=0.
REQ-025 fib_done outside WAIT SHALL be ignored.
REQ-026 RESP: resp_valid=1 for exactly one cycle with latched qualifiers and resp_dir = granted dir; -> IDLE.
REQ-027 Min latency: req rises cycle t, FSM in IDLE, other slot empty -> fib_valid at t+2; fib_done at cycle d -> resp_valid at d+1.
REQ-028 Captures into the non-granted slot SHALL proceed during ISSUE/WAIT/RESP.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, both slots empty, timer 0, last_grant = !FIRST_PRIORITY, all outputs 0 (prefix/len buses 0).
REQ-030 Reset mid-transaction SHALL discard pending and in-flight requests with no response.
REQ-031 Reset release SHALL be synchronized externally; first capture possible on the first edge after rst=1.

Structure
REQ-032 Shared package ndn_pkg SHALL hold PREFIX_W=64, LEN_W=6, direction encoding, FSM state enum.
REQ-033 Sub-module fib_req_slot (capture register + ack pulse + re-arm logic) SHALL be instantiated twice.
REQ-034 Target size 150-300 lines RTL; no combinational path from fib_* inputs to fib_valid.

Verification
REQ-035 out_req, prefix 64'h0000FFFF0000FFFF, len 10, fib_ready=1, fib_done+hit 3 cycles later -> out_ack at t+1, fib_valid at t+2, resp_valid dir=0 hit=1.
REQ-036 out_req and in_req same cycle after reset (FIRST_PRIORITY=0) -> outgoing issued first, incoming second; repeat -> incoming first.
REQ-037 in_req len 10, FIB returns done+rejected -> resp_valid dir=1 rejected=1 hit=0.
REQ-038 in_req, fib_ready=1, no fib_done, TIMEOUT_CYCLES=4 -> resp_valid timeout=1 exactly 4 cycles after transfer; done on that cycle -> timeout=0.
REQ-039 out_req len 0 -> no fib_valid, resp_valid rejected=1; rst=0 during WAIT -> all outputs 0, no resp_valid after release.
